// File: rtl/ap_ctrl_txn_recorder.sv
// Purpose: records each ap_ctrl_hs transaction as {start_ts, latency, id} on a valid/ready stream.
// Latency: a record reaches rec_valid two cycles after its ap_done cycle when the record FIFO is empty.
// Backpressure: records are held stable while rec_ready=0; a full record FIFO drops new records (drop_count).

// Small generic synchronous FIFO; the caller guarantees no push when full without a pop, and no pop when empty.
module txn_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_dat,
    output logic         o_empty,
    output logic         o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;

    assign o_dat   = r_mem[r_rd];
    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == (AW+1)'(DEPTH));

    // Storage array is not reset; only pointers and occupancy define validity.
    always_ff @(posedge clock) begin
        if (i_push) begin
            r_mem[r_wr] <= i_dat;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (i_pop)  r_rd <= r_rd + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

module ap_ctrl_txn_recorder #(
    parameter int TS_W      = 32,
    parameter int CNT_W     = 16,
    parameter int INFLIGHT  = 4,
    parameter int REC_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic             finish,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [TS_W-1:0]  rec_start_ts,
    output logic [TS_W-1:0]  rec_latency,
    output logic [CNT_W-1:0] rec_id,
    output logic [CNT_W-1:0] txn_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             proto_err,
    output logic             busy,
    output logic             flushed
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT_READY, S_FLUSH} state_t;

    typedef struct packed {
        logic [TS_W-1:0]  start_ts;
        logic [TS_W-1:0]  latency;
        logic [CNT_W-1:0] id;
    } rec_t;

    state_t           r_state, w_state_nxt;
    logic [TS_W-1:0]  r_ts;
    logic [CNT_W-1:0] r_id, r_txn, r_drop;
    logic             r_perr;
    logic             r_stg_vld;
    rec_t             r_stg;

    logic [TS_W-1:0]  w_sq_dat, w_start_ts;
    logic             w_sq_empty, w_sq_full, w_sq_push, w_sq_pop;
    logic             w_push_req, w_comp, w_bypass, w_start_ok;
    logic             w_push_err, w_comp_err, w_wait_err, w_rec_fire;
    rec_t             w_rf_rec;
    logic             w_rf_empty, w_rf_full, w_rf_push, w_rf_pop, w_drop;

    // A start is only considered in S_IDLE, which also blocks starts once finish is latched (S_FLUSH).
    assign w_push_req = (r_state == S_IDLE) && ap_start;
    assign w_comp     = ap_done && ap_continue;
    // Start and done in the same cycle with nothing pending: hand the timestamp straight to the record.
    assign w_bypass   = w_push_req && w_comp && w_sq_empty;
    assign w_sq_pop   = w_comp && !w_sq_empty;
    assign w_sq_push  = w_push_req && !w_bypass && (!w_sq_full || w_sq_pop);
    assign w_start_ok = w_bypass || w_sq_push;
    assign w_push_err = w_push_req && !w_start_ok;
    assign w_rec_fire = w_bypass || w_sq_pop;
    assign w_comp_err = w_comp && !w_rec_fire;
    assign w_start_ts = w_bypass ? r_ts : w_sq_dat;

    txn_fifo #(.W(TS_W), .DEPTH(INFLIGHT)) u_start_q (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_sq_push),
        .i_dat   (r_ts),
        .i_pop   (w_sq_pop),
        .o_dat   (w_sq_dat),
        .o_empty (w_sq_empty),
        .o_full  (w_sq_full)
    );

    // Record FIFO: a full FIFO still accepts a write when the consumer pops in the same cycle.
    assign w_rf_pop  = !w_rf_empty && rec_ready;
    assign w_rf_push = r_stg_vld && (!w_rf_full || w_rf_pop);
    assign w_drop    = r_stg_vld && !w_rf_push;

    txn_fifo #(.W($bits(rec_t)), .DEPTH(REC_DEPTH)) u_rec_q (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_rf_push),
        .i_dat   (r_stg),
        .i_pop   (w_rf_pop),
        .o_dat   (w_rf_rec),
        .o_empty (w_rf_empty),
        .o_full  (w_rf_full)
    );

    // Start FSM next state; finish overrides everything and S_FLUSH is left only through reset.
    always_comb begin
        w_state_nxt = r_state;
        w_wait_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok && !ap_ready) w_state_nxt = S_WAIT_READY;
            end
            S_WAIT_READY: begin
                if (ap_ready) begin
                    w_state_nxt = S_IDLE;
                end else if (!ap_start) begin
                    // start dropped before ready: flag it, keep the already pushed timestamp
                    w_wait_err  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_FLUSH:  w_state_nxt = S_FLUSH;
            default:  w_state_nxt = S_IDLE;
        endcase
        if (finish) w_state_nxt = S_FLUSH;
    end

    // State register, timestamp, id/counters, sticky error and the one-deep record staging register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ts      <= '0;
            r_id      <= '0;
            r_txn     <= '0;
            r_drop    <= '0;
            r_perr    <= 1'b0;
            r_stg_vld <= 1'b0;
            r_stg     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ts      <= r_ts + 1'b1;
            r_stg_vld <= w_rec_fire;
            if (w_rec_fire) begin
                r_stg.start_ts <= w_start_ts;
                r_stg.latency  <= r_ts - w_start_ts;
                r_stg.id       <= r_id;
                r_id           <= r_id + 1'b1;
                if (r_txn != '1) r_txn <= r_txn + 1'b1;
            end
            if (w_drop && (r_drop != '1)) r_drop <= r_drop + 1'b1;
            if (w_push_err || w_comp_err || w_wait_err) r_perr <= 1'b1;
        end
    end

    // Record data reads as zero whenever no record is presented.
    assign rec_valid    = !w_rf_empty;
    assign rec_start_ts = rec_valid ? w_rf_rec.start_ts : '0;
    assign rec_latency  = rec_valid ? w_rf_rec.latency  : '0;
    assign rec_id       = rec_valid ? w_rf_rec.id       : '0;
    assign txn_count    = r_txn;
    assign drop_count   = r_drop;
    assign proto_err    = r_perr;
    assign busy         = !w_sq_empty || (r_state == S_WAIT_READY);
    // A record still in the staging register counts as not yet drained.
    assign flushed      = (r_state == S_FLUSH) && w_rf_empty && !r_stg_vld;
endmodule

// File: tb/tb_ap_ctrl_txn_recorder.sv
// Purpose: directed self-checking bench for ap_ctrl_txn_recorder.
// Latency: inputs driven 1 time unit after each rising edge; outputs checked at the same point.
// Backpressure: rec_ready is held low to accumulate records and raised per record to drain them.
module tb_ap_ctrl_txn_recorder;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ap_start = 1'b0, ap_ready = 1'b0, ap_done = 1'b0, ap_continue = 1'b1;
    logic        finish = 1'b0, rec_ready = 1'b0;
    logic        rec_valid, proto_err, busy, flushed;
    logic [31:0] rec_start_ts, rec_latency;
    logic [15:0] rec_id, txn_count, drop_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;  // bench-side model of the DUT timestamp

    ap_ctrl_txn_recorder dut (
        .clock        (clock),
        .reset        (reset),
        .ap_start     (ap_start),
        .ap_ready     (ap_ready),
        .ap_done      (ap_done),
        .ap_continue  (ap_continue),
        .finish       (finish),
        .rec_valid    (rec_valid),
        .rec_ready    (rec_ready),
        .rec_start_ts (rec_start_ts),
        .rec_latency  (rec_latency),
        .rec_id       (rec_id),
        .txn_count    (txn_count),
        .drop_count   (drop_count),
        .proto_err    (proto_err),
        .busy         (busy),
        .flushed      (flushed)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task tick;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task go_to(input int n);
        while (cyc < n) tick();
    endtask

    task do_reset;
        reset = 1'b1;
        ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0;
        finish = 1'b0; rec_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        cyc = 0;
    endtask

    task set_hs(input logic s, input logic r, input logic d);
        ap_start = s; ap_ready = r; ap_done = d;
    endtask

    // check the head record, then consume it in the following clock edge
    task pop_chk(input string tag, input int st, input int lat, input int id);
        chk({tag, ".vld"}, 32'(rec_valid), 1);
        chk({tag, ".start_ts"}, rec_start_ts, st);
        chk({tag, ".latency"}, rec_latency, lat);
        chk({tag, ".id"}, 32'(rec_id), id);
        rec_ready = 1'b1;
        tick();
        rec_ready = 1'b0;
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst.rec_valid", 32'(rec_valid), 0);
        chk("rst.proto_err", 32'(proto_err), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.flushed", 32'(flushed), 0);
        chk("rst.txn_count", 32'(txn_count), 0);
        chk("rst.drop_count", 32'(drop_count), 0);
        chk("rst.rec_start_ts", rec_start_ts, 0);

        // single transaction: start at 10, ready at 12, done at 17
        go_to(10); set_hs(1, 0, 0);
        tick(); chk("t1.busy_wait", 32'(busy), 1);
        go_to(12); set_hs(1, 1, 0);
        tick(); set_hs(0, 0, 0);
        go_to(17); ap_done = 1'b1;
        tick(); ap_done = 1'b0;
        chk("t1.vld_at18", 32'(rec_valid), 0);
        chk("t1.txn_count", 32'(txn_count), 1);
        tick();
        chk("t1.proto_err", 32'(proto_err), 0);
        pop_chk("t1.rec", 10, 7, 0);
        chk("t1.vld_after_pop", 32'(rec_valid), 0);

        // pipelined overlap: starts at 5,6,7 and dones at 20,21,22
        do_reset();
        go_to(5); set_hs(1, 1, 0);
        go_to(8); set_hs(0, 0, 0);
        chk("t2.busy_inflight", 32'(busy), 1);
        go_to(20); ap_done = 1'b1;
        go_to(22); chk("t2.busy_at22", 32'(busy), 1);
        tick(); ap_done = 1'b0;
        chk("t2.busy_at23", 32'(busy), 0);
        tick();
        pop_chk("t2.rec0", 5, 15, 0);
        pop_chk("t2.rec1", 6, 15, 1);
        pop_chk("t2.rec2", 7, 15, 2);
        chk("t2.txn_count", 32'(txn_count), 3);

        // back-pressure: six zero-latency completions at 2..7 into a 4-deep FIFO
        do_reset();
        go_to(2); set_hs(1, 1, 1);
        go_to(8); set_hs(0, 0, 0);
        go_to(10);
        chk("t3.drop_count", 32'(drop_count), 2);
        chk("t3.txn_count", 32'(txn_count), 6);
        for (int i = 0; i < 4; i++) pop_chk("t3.rec", 2 + i, 0, i);
        chk("t3.drained", 32'(rec_valid), 0);
        go_to(20); set_hs(1, 1, 1);
        tick(); set_hs(0, 0, 0);
        tick();
        pop_chk("t3.next_id", 20, 0, 6);

        // zero latency with an empty queue at ts=30
        do_reset();
        go_to(30); set_hs(1, 1, 1);
        tick(); set_hs(0, 0, 0);
        chk("t4.vld_at31", 32'(rec_valid), 0);
        tick();
        chk("t4.proto_err", 32'(proto_err), 0);
        pop_chk("t4.rec", 30, 0, 0);

        // protocol error: done with nothing pending
        do_reset();
        go_to(3); ap_done = 1'b1;
        tick(); ap_done = 1'b0;
        chk("t5a.proto_err", 32'(proto_err), 1);
        chk("t5a.txn_count", 32'(txn_count), 0);
        tick();
        chk("t5a.no_record", 32'(rec_valid), 0);

        // protocol error: five starts at 2..6 into a 4-deep start queue, then four dones at 10..13
        do_reset();
        go_to(2); set_hs(1, 1, 0);
        go_to(7); set_hs(0, 0, 0);
        chk("t5b.proto_err", 32'(proto_err), 1);
        chk("t5b.busy", 32'(busy), 1);
        go_to(10); ap_done = 1'b1;
        go_to(14); ap_done = 1'b0;
        chk("t5b.queue_empty", 32'(busy), 0);
        tick();
        for (int i = 0; i < 4; i++) pop_chk("t5b.rec", 2 + i, 8, i);
        chk("t5b.txn_count", 32'(txn_count), 4);

        // finish with two queued records, then reset
        do_reset();
        go_to(2); set_hs(1, 1, 1);
        go_to(4); set_hs(0, 0, 0);
        go_to(6); finish = 1'b1; rec_ready = 1'b1;
        chk("t6.vld_at6", 32'(rec_valid), 1);
        chk("t6.flushed_at6", 32'(flushed), 0);
        tick(); finish = 1'b0; set_hs(1, 1, 0);
        chk("t6.flushed_at7", 32'(flushed), 0);
        tick(); set_hs(0, 0, 0);
        chk("t6.flushed_at8", 32'(flushed), 1);
        chk("t6.no_new_start", 32'(busy), 0);
        chk("t6.drained", 32'(rec_valid), 0);
        chk("t6.txn_count", 32'(txn_count), 2);
        ap_done = 1'b1;
        tick(); ap_done = 1'b0;
        chk("t6.perr_orphan_done", 32'(proto_err), 1);
        chk("t6.flushed_held", 32'(flushed), 1);
        reset = 1'b1;
        tick();
        chk("t6.rst.flushed", 32'(flushed), 0);
        chk("t6.rst.proto_err", 32'(proto_err), 0);
        chk("t6.rst.txn_count", 32'(txn_count), 0);
        chk("t6.rst.busy", 32'(busy), 0);
        chk("t6.rst.rec_valid", 32'(rec_valid), 0);
        chk("t6.rst.rec_id", 32'(rec_id), 0);
        reset = 1'b0;
        rec_ready = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
